// File: rtl/bmc_soft_punct.sv
// Soft-decision branch metric unit with programmable puncturing and erasures.
// Two-stage valid/ready pipeline: per-symbol distances, then per-pattern sums.
module bmc_soft_punct #(
   parameter int unsigned R_OUT = 2,
   parameter int unsigned SW = 3,
   parameter int unsigned MW = SW + $clog2(R_OUT),
   parameter int unsigned PUNCT_PERIOD = 1,
   parameter logic [PUNCT_PERIOD*R_OUT-1:0] PUNCT_MASK = '1,
   parameter int unsigned PW = (PUNCT_PERIOD > 1) ? $clog2(PUNCT_PERIOD) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_sof,
   input  logic [R_OUT*SW-1:0]        in_rx,
   input  logic [R_OUT-1:0]           in_erase,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [(2**R_OUT)*MW-1:0]   out_bm,
   output logic [PW-1:0]              out_phase
);

   localparam int unsigned NP = 2 ** R_OUT;
   localparam logic [SW-1:0] SMAX = '1;

   logic                  accept;
   logic [PW-1:0]         ph_q, ph_d, ph_used;
   logic [R_OUT-1:0]      keep;
   logic [R_OUT*SW-1:0]   d0_d, d1_d, d0_q, d1_q;
   logic                  s1_valid;
   logic [PW-1:0]         s1_phase;
   logic [NP*MW-1:0]      bm_d;
   logic [MW-1:0]         acc;

   // Whole pipeline stalls while the output register is held.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      ph_used = in_sof ? '0 : ph_q;
      ph_d    = ph_q;
      if (accept) begin
         if (32'(ph_used) == PUNCT_PERIOD - 1) begin
            ph_d = '0;
         end else begin
            ph_d = ph_used + 1'b1;
         end
      end
   end

   always_comb begin
      keep = '0;
      for (int ph = 0; ph < int'(PUNCT_PERIOD); ph++) begin
         if (ph_used == PW'(ph)) begin
            keep = PUNCT_MASK[ph*R_OUT +: R_OUT];
         end
      end
      keep = keep & ~in_erase;
      d0_d = '0;
      d1_d = '0;
      for (int i = 0; i < int'(R_OUT); i++) begin
         if (keep[i]) begin
            d0_d[i*SW +: SW] = in_rx[i*SW +: SW];
            d1_d[i*SW +: SW] = SMAX - in_rx[i*SW +: SW];
         end
      end
   end

   // Bit i of the pattern index selects the distance to an expected '1' for symbol i.
   always_comb begin
      bm_d = '0;
      acc  = '0;
      for (int p = 0; p < int'(NP); p++) begin
         acc = '0;
         for (int i = 0; i < int'(R_OUT); i++) begin
            if (p[i]) begin
               acc = acc + MW'(d1_q[i*SW +: SW]);
            end else begin
               acc = acc + MW'(d0_q[i*SW +: SW]);
            end
         end
         bm_d[p*MW +: MW] = acc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph_q      <= '0;
         s1_valid  <= 1'b0;
         d0_q      <= '0;
         d1_q      <= '0;
         s1_phase  <= '0;
         out_valid <= 1'b0;
         out_bm    <= '0;
         out_phase <= '0;
      end else begin
         ph_q <= ph_d;
         if (in_ready) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
               d0_q     <= d0_d;
               d1_q     <= d1_d;
               s1_phase <= ph_used;
            end
            if (s1_valid) begin
               out_bm    <= bm_d;
               out_phase <= s1_phase;
            end
         end
      end
   end

endmodule

// File: tb/tb_bmc_soft_punct.sv
// Directed bench for bmc_soft_punct configured as rate 2/3 (period 2, mask 0111).
// Phase-0 groups see both symbols, so they also exercise the unpunctured metric path.
module tb_bmc_soft_punct;

   localparam int unsigned R_OUT = 2;
   localparam int unsigned SW = 3;
   localparam int unsigned MW = 4;
   localparam int unsigned PP = 2;
   localparam logic [3:0] MASK = 4'b0111;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sof;
   logic [5:0]  in_rx;
   logic [1:0]  in_erase;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_bm;
   logic [0:0]  out_phase;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bmc_soft_punct #(
      .R_OUT(R_OUT),
      .SW(SW),
      .MW(MW),
      .PUNCT_PERIOD(PP),
      .PUNCT_MASK(MASK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_sof(in_sof),
      .in_rx(in_rx),
      .in_erase(in_erase),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_bm(out_bm),
      .out_phase(out_phase)
   );

   task automatic drive(input logic v, input logic s, input logic [5:0] rx, input logic [1:0] er);
      in_valid = v;
      in_sof   = s;
      in_rx    = rx;
      in_erase = er;
   endtask

   // Independent metric model: kept symbol costs v against '0' and 7-v against '1'.
   function automatic logic [16:0] model(input logic [5:0] rx, input logic [1:0] er, input int ph);
      logic [15:0] r;
      logic [3:0]  a;
      logic [3:0]  m;
      logic [2:0]  v;
      m = MASK;
      r = '0;
      for (int p = 0; p < 4; p++) begin
         a = '0;
         for (int i = 0; i < 2; i++) begin
            v = rx[i*3 +: 3];
            if (m[ph*2+i] && !er[i]) a = a + (p[i] ? {1'b0, 3'd7 - v} : {1'b0, v});
         end
         r[p*4 +: 4] = a;
      end
      return {ph[0], r};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 1'b0, 6'd0, 2'd0);
      #7;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (out_bm !== 16'h0) begin errors++; $display("FAIL reset_bm got=%h exp=0000", out_bm); end
      checks++; if (out_phase !== 1'b0) begin errors++; $display("FAIL reset_phase got=%b exp=0", out_phase); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic();
      @(negedge clk);
      drive(1'b1, 1'b1, {3'd7, 3'd0}, 2'b00);
      @(negedge clk);
      drive(1'b0, 1'b0, 6'd0, 2'd0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got=%b exp=0", out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      checks++; if (out_bm !== 16'h70E7) begin errors++; $display("FAIL basic_bm got=%h exp=70e7", out_bm); end
      checks++; if (out_phase !== 1'b0) begin errors++; $display("FAIL basic_phase got=%b exp=0", out_phase); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_after got=%b exp=0", out_valid); end
   endtask

   // use_sof=1 also marks the 2nd group as start of frame.
   task automatic test_punct(input logic use_sof);
      logic [15:0] eb [4];
      logic        ep [4];
      if (use_sof) begin
         eb = '{16'hE770, 16'hE770, 16'h7070, 16'hE770};
         ep = '{1'b0, 1'b0, 1'b1, 1'b0};
      end else begin
         eb = '{16'hE770, 16'h7070, 16'hE770, 16'h7070};
         ep = '{1'b0, 1'b1, 1'b0, 1'b1};
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k >= 2) begin
            checks++;
            if (out_valid !== 1'b1 || out_bm !== eb[k-2] || out_phase !== ep[k-2]) begin
               errors++;
               $display("FAIL punct%0d_grp%0d got v=%b bm=%h ph=%b exp v=1 bm=%h ph=%b",
                        use_sof, k-2, out_valid, out_bm, out_phase, eb[k-2], ep[k-2]);
            end
         end
         if (k < 4) drive(1'b1, (k == 0) || (use_sof && k == 1), 6'd0, 2'b00);
         else drive(1'b0, 1'b0, 6'd0, 2'd0);
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL punct%0d_drain got=%b exp=0", use_sof, out_valid); end
   endtask

   task automatic test_erase();
      @(negedge clk);
      drive(1'b1, 1'b1, {3'd5, 3'd2}, 2'b11);
      @(negedge clk);
      drive(1'b0, 1'b0, 6'd0, 2'd0);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL erase_valid got=%b exp=1", out_valid); end
      checks++; if (out_bm !== 16'h0000) begin errors++; $display("FAIL erase_bm got=%h exp=0000", out_bm); end
   endtask

   task automatic test_back_to_back();
      logic [16:0] expq [$];
      logic [16:0] e;
      logic [15:0] held;
      logic        stalled;
      logic [5:0]  r;
      logic [1:0]  er;
      logic        s;
      int          sent, got, ph_m, ph_use;
      sent = 0; got = 0; ph_m = 0; stalled = 1'b0; held = '0;
      for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_bm !== held) begin
               errors++;
               $display("FAIL bp_stable got v=%b bm=%h exp v=1 bm=%h", out_valid, out_bm, held);
            end
         end
         out_ready = (cyc == 3 || cyc == 4) ? 1'b0 : 1'($urandom_range(0, 1));
         if (sent < 8) begin
            r  = 6'($urandom);
            er = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            s  = (sent == 0) || (sent == 5);
            drive(1'b1, s, r, er);
         end else begin
            drive(1'b0, 1'b0, 6'd0, 2'd0);
         end
         #1;
         checks++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("FAIL bp_ready got=%b exp=%b", in_ready, !(out_valid && !out_ready));
         end
         if (out_valid && out_ready) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL bp_extra got=%h exp=none", {out_phase, out_bm});
            end else begin
               e = expq.pop_front();
               if ({out_phase, out_bm} !== e) begin
                  errors++;
                  $display("FAIL bp_data%0d got=%h exp=%h", got, {out_phase, out_bm}, e);
               end
            end
            got++;
         end
         stalled = out_valid && !out_ready;
         held = out_bm;
         if (in_valid && in_ready) begin
            ph_use = in_sof ? 0 : ph_m;
            expq.push_back(model(in_rx, in_erase, ph_use));
            ph_m = (ph_use == int'(PP) - 1) ? 0 : ph_use + 1;
            sent++;
         end
      end
      checks++; if (got != 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", got); end
      checks++; if (expq.size() != 0) begin errors++; $display("FAIL bp_left got=%0d exp=0", expq.size()); end
      drive(1'b0, 1'b0, 6'd0, 2'd0);
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1'b1, k == 0, 6'h3F, 2'b00);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 6'd0, 2'd0);
      out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
      checks++; if (out_bm !== 16'h0) begin errors++; $display("FAIL rstmid_bm got=%h exp=0000", out_bm); end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
      drive(1'b1, 1'b0, 6'd0, 2'b00);
      @(negedge clk);
      drive(1'b0, 1'b0, 6'd0, 2'd0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale got=%b exp=0", out_valid); end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_bm !== 16'hE770 || out_phase !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_first got v=%b bm=%h ph=%b exp v=1 bm=e770 ph=0", out_valid, out_bm, out_phase);
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after got=%b exp=0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_punct(1'b0);
      test_punct(1'b1);
      test_erase();
      test_back_to_back();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bmc_soft_punct.md
# bmc_soft_punct

Parametrised soft-decision branch metric unit for the Viterbi decoder. Each accepted received symbol group has R_OUT soft values. For that group the unit computes the Hamming-style soft distance to every one of the 2^R_OUT possible expected code-bit patterns. Distance contribution is suppressed for punctured positions (a programmable repeating pattern) and for erased positions. Results go through a two-stage valid/ready pipeline that feeds the ACS array, and this unit replaces the fixed hard-decision rate-1/2 BMC slices.

## Interface
- R_OUT, 2, code outputs per trellis step (1..4)
- SW, 3, soft-value width; offset binary, 0 = strongest '0', 2^SW-1 = strongest '1'
- MW, SW+$clog2(R_OUT) (R_OUT=1 gives SW), width of one branch metric
- PUNCT_PERIOD, 1, puncture pattern length in trellis steps (1..8)
- PUNCT_MASK, all ones, PUNCT_PERIOD*R_OUT bits; bit [ph*R_OUT+i] = 1 means symbol i is transmitted in phase ph, 0 means punctured
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  rx group valid
- in_ready  out  1  unit accepts group this cycle
- in_sof  in  1  first group of a frame; forces puncture phase 0 for this group
- in_rx  in  R_OUT*SW  soft values; symbol i = in_rx[i*SW +: SW]
- in_erase  in  R_OUT  per-symbol erasure; 1 = contributes zero
- out_valid  out  1  metrics valid
- out_ready  in  1  downstream accepts
- out_bm  out  (2^R_OUT)*MW  metric for expected pattern p at out_bm[p*MW +: MW]; bit i of p = expected bit for symbol i
- out_phase  out  $clog2(PUNCT_PERIOD) or 1  puncture phase used for this group

## Operation
- Accept occurs when in_valid && in_ready. in_ready = !out_valid || out_ready, so the pipeline as a whole stalls while the output is held.
- Phase counter: ph_used = 0 if in_sof, else ph. On accept, ph <= (ph_used == PUNCT_PERIOD-1) ? 0 : ph_used+1. Without an accept the counter holds. With PUNCT_PERIOD=1 the counter is constantly 0.
- Stage 1 registers the following for each symbol i:
  - keep_i = PUNCT_MASK[ph_used*R_OUT+i] && !in_erase[i]
  - d0_i = keep_i ? rx_i : 0
  - d1_i = keep_i ? (2^SW-1 - rx_i) : 0
  - ph_used
- Stage 2 computes, for each pattern p, bm_p = sum over i of (p[i] ? d1_i : d0_i), zero-extended to MW. This never overflows: the maximum is R_OUT*(2^SW-1).
- If every symbol is punctured or erased, all metrics are 0, and the group still produces output (the trellis step advances).
- No normalisation is done here; the ACS handles that.

## Timing
- Latency from accept to out_valid is 2 cycles when no stall occurs. Throughput is 1 group/cycle while out_ready=1.
- Output register stays stable while out_valid && !out_ready. Stage-1 contents also hold in that case, and no data is lost or duplicated.
- A stage advances only when its successor is free. Stage 1 with its valid bit clear counts as a bubble, and bubbles collapse when out_ready is high.
- Reset (async assert, takes effect immediately) sets:
  - out_valid=0, out_bm=0, out_phase=0
  - stage-1 valid=0, stage-1 data 0, ph=0
  - in_ready=1 in the first cycle after release
- Reset mid-frame drops any in-flight groups, and the phase restarts at 0.
- in_sof on the same cycle as phase wrap: in_sof wins, ph_used=0, next ph=1 (or 0 if PUNCT_PERIOD=1).
- in_sof without in_valid, or while in_ready=0, has no effect.

## Test plan
- R_OUT=2, SW=3, default mask. Accept in_rx={7,0} (sym1=7, sym0=0), erase=0, out_ready=1. Required: out_valid exactly 2 cycles later with out_bm=16'h70E7 (p3=7, p2=0, p1=14, p0=7) and out_phase=0.
- Rate 2/3: PUNCT_PERIOD=2, PUNCT_MASK=4'b0111. Send four groups, all in_rx={0,0}. Required outputs:
  - phase 0 groups: bm p0..p3 = 0,7,7,14
  - phase 1 groups: bm p0..p3 = 0,7,0,7
  - out_phase sequence: 0,1,0,1
- in_sof on the 2nd group of the previous scenario. Required out_phase sequence: 0,0,1,0, with metrics matching each phase.
- in_erase=2'b11 with in_rx={5,2}. Required: all four metrics 0 and out_valid still asserted.
- Backpressure: stream 8 groups with random out_ready. Required:
  - output matches a reference-model sequence in order, with no drop or duplicate
  - out_bm stable while stalled
  - in_ready=0 exactly when out_valid && !out_ready
- Async reset asserted with 2 groups in flight and ph=1. Required:
  - out_valid=0 immediately
  - after release the first group is processed with phase 0
  - the in-flight groups never appear at the output
